// File: rtl/m9k_mp_controller.sv
// ---------------------------------------------------------------------------
// m9k_mp_controller
//
// Multi-channel scratchpad controller for one inferred M9K-style RAM.
// NUM_CH request channels are arbitrated round-robin, and the RAM accepts
// at most one access per cycle. Reads have one cycle of registered latency.
// Writes support per-byte enables. A clear sequencer zeroes the whole array
// one word per cycle, because the array itself is never reset.
//
// Ports:
//   clk        system clock, rising edge
//   rst_l      asynchronous active-low reset
//   req        per-channel request, held until granted
//   we         per-channel write (1) / read (0)
//   addr       per-channel word address, channel i in slice i
//   wdata      per-channel write data, channel i in slice i
//   be         per-channel byte enables, channel i in slice i
//   gnt        one-hot combinational grant
//   rvalid     per-channel one-cycle read-complete pulse
//   rdata      registered read data, shared by all channels
//   clr_start  single-cycle pulse that starts the array clear
//   busy       high while the clear sequence runs
// ---------------------------------------------------------------------------
module m9k_mp_controller #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 15,
    parameter int DEPTH  = 1024,
    parameter int NUM_CH = 2
) (
    input  logic                           clk,
    input  logic                           rst_l,
    input  logic [NUM_CH-1:0]              req,
    input  logic [NUM_CH-1:0]              we,
    input  logic [NUM_CH*ADDR_W-1:0]       addr,
    input  logic [NUM_CH*DATA_W-1:0]       wdata,
    input  logic [NUM_CH*(DATA_W/8)-1:0]   be,
    output logic [NUM_CH-1:0]              gnt,
    output logic [NUM_CH-1:0]              rvalid,
    output logic [DATA_W-1:0]              rdata,
    input  logic                           clr_start,
    output logic                           busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned NCH = NUM_CH;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Array: deliberately no reset so it maps onto block RAM
    logic [DATA_W-1:0] mem [DEPTH];

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic               busy_q, busy_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_CH-1:0]  rvalid_q, rvalid_d;
    logic [DATA_W-1:0]  rdata_q;

    // Arbitration results
    logic [NUM_CH-1:0]  gnt_c;
    logic               grant_any;
    logic [PTR_W-1:0]   grant_ch;

    // Selected channel's request fields
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [BE_W-1:0]    sel_be;
    logic               sel_in_range;

    // RAM port controls
    logic               mem_we;
    logic [IDX_W-1:0]   mem_idx;
    logic [DATA_W-1:0]  mem_wdata;
    logic [BE_W-1:0]    mem_be;
    logic               rd_en;
    logic               rd_hit;

    // -----------------------------------------------------------------------
    // Round-robin arbiter: search upward from ptr_q, wrapping at NUM_CH.
    // No grant during reset, while clearing, or when a clear is starting.
    // -----------------------------------------------------------------------
    always_comb begin
        int unsigned cand;
        gnt_c     = '0;
        grant_any = 1'b0;
        grant_ch  = '0;
        cand      = 0;
        if (rst_l && (state_q == ST_IDLE) && !clr_start) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                cand = int'(ptr_q) + i;
                if (cand >= NCH) begin
                    cand = cand - NCH;
                end
                if (!grant_any && req[cand]) begin
                    grant_any   = 1'b1;
                    grant_ch    = PTR_W'(cand);
                    gnt_c[cand] = 1'b1;
                end
            end
        end
    end

    // Mux the granted channel's request fields
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int unsigned ch = 0; ch < NCH; ch++) begin
            if (gnt_c[ch]) begin
                sel_we    = we[ch];
                sel_addr  = addr[ch*ADDR_W +: ADDR_W];
                sel_wdata = wdata[ch*DATA_W +: DATA_W];
                sel_be    = be[ch*BE_W +: BE_W];
            end
        end
        // Full-width compare; the extra bit keeps DEPTH == 2**ADDR_W exact
        sel_in_range = ({1'b0, sel_addr} < (ADDR_W+1)'(DEPTH));
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        busy_d    = busy_q;
        ptr_d     = ptr_q;
        rvalid_d  = '0;
        mem_we    = 1'b0;
        mem_idx   = '0;
        mem_wdata = '0;
        mem_be    = '0;
        rd_en     = 1'b0;
        rd_hit    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                    busy_d    = 1'b1;
                end else if (grant_any) begin
                    if (grant_ch == PTR_W'(NUM_CH - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = grant_ch + 1'b1;
                    end
                    mem_idx = sel_addr[IDX_W-1:0];
                    if (sel_we) begin
                        // Out-of-range writes are dropped
                        mem_we    = sel_in_range;
                        mem_wdata = sel_wdata;
                        mem_be    = sel_be;
                    end else begin
                        rd_en    = 1'b1;
                        rd_hit   = sel_in_range;
                        rvalid_d = gnt_c;
                    end
                end
            end

            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_idx   = clr_cnt_q[IDX_W-1:0];
                mem_wdata = '0;
                mem_be    = '1;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == CNT_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Control state and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
            busy_q    <= 1'b0;
            ptr_q     <= '0;
            rvalid_q  <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
            ptr_q     <= ptr_d;
            rvalid_q  <= rvalid_d;
            // The RAM read is taken here rather than through an rdata_d so
            // the array is read synchronously; rdata holds between reads.
            if (rd_en) begin
                rdata_q <= rd_hit ? mem[mem_idx] : '0;
            end
        end
    end

    // Array write port with per-byte enables
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < BE_W; b++) begin
                if (mem_be[b]) begin
                    mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    assign gnt    = gnt_c;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_m9k_mp_controller.sv
// ---------------------------------------------------------------------------
// tb_m9k_mp_controller
//
// Self-checking bench for m9k_mp_controller with default parameters.
// A behavioural model (word array, round-robin pointer, last read data)
// produces every expected value.
// ---------------------------------------------------------------------------
module tb_m9k_mp_controller;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 15;
    localparam int DEPTH  = 1024;
    localparam int NUM_CH = 2;
    localparam int BE_W   = DATA_W / 8;

    logic                        clk = 1'b0;
    logic                        rst_l = 1'b0;
    logic [NUM_CH-1:0]           req;
    logic [NUM_CH-1:0]           we;
    logic [NUM_CH*ADDR_W-1:0]    addr;
    logic [NUM_CH*DATA_W-1:0]    wdata;
    logic [NUM_CH*BE_W-1:0]      be;
    logic [NUM_CH-1:0]           gnt;
    logic [NUM_CH-1:0]           rvalid;
    logic [DATA_W-1:0]           rdata;
    logic                        clr_start;
    logic                        busy;

    int tests = 0;
    int fails = 0;

    // Reference model
    logic [DATA_W-1:0] mdl [DEPTH];
    int                mptr;
    logic [DATA_W-1:0] m_rdata;

    m9k_mp_controller #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .NUM_CH (NUM_CH)
    ) dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .be        (be),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .clr_start (clr_start),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic void mdl_write(input int a, input logic [DATA_W-1:0] d,
                                      input logic [BE_W-1:0] b);
        if (a < DEPTH) begin
            for (int i = 0; i < BE_W; i++) begin
                if (b[i]) mdl[a][8*i +: 8] = d[8*i +: 8];
            end
        end
    endfunction

    function automatic logic [DATA_W-1:0] mdl_read(input int a);
        return (a < DEPTH) ? mdl[a] : '0;
    endfunction

    function automatic int exp_grant(input logic [NUM_CH-1:0] r);
        for (int off = 0; off < NUM_CH; off++) begin
            int c;
            c = (mptr + off) % NUM_CH;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic idle_inputs();
        req       = '0;
        we        = '0;
        addr      = '0;
        wdata     = '0;
        be        = '0;
        clr_start = 1'b0;
    endtask

    // One single-channel access. Entered at posedge+1, returns at posedge+1.
    task automatic access(input int ch, input bit w, input int a,
                          input logic [DATA_W-1:0] d, input logic [BE_W-1:0] b,
                          output logic [NUM_CH-1:0] g,
                          output logic [NUM_CH-1:0] rv,
                          output logic [DATA_W-1:0] rd);
        logic [31:0] av;
        av = a;
        idle_inputs();
        req[ch]                   = 1'b1;
        we[ch]                    = w;
        addr[ch*ADDR_W +: ADDR_W] = av[ADDR_W-1:0];
        wdata[ch*DATA_W +: DATA_W] = d;
        be[ch*BE_W +: BE_W]       = b;
        #3;
        g = gnt;
        @(posedge clk); #1;
        req = '0;
        rv  = rvalid;
        rd  = rdata;
        mptr = (ch + 1) % NUM_CH;
        if (w) mdl_write(a, d, b);
        else   m_rdata = mdl_read(a);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_l = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (gnt !== '0) begin fails++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
        tests++; if (rvalid !== '0) begin fails++; $display("FAIL reset_rvalid: got %b expected 00", rvalid); end
        tests++; if (rdata !== '0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst_l = 1'b1;
        mptr = 0;
        m_rdata = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_clear();
        int  n;
        bit  gnt_seen;
        idle_inputs();
        clr_start = 1'b1;
        @(posedge clk); #1;
        clr_start = 1'b0;
        req = 2'b11;   // held through the clear, must stay pending
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL clear_busy_rise: got %b expected 1", busy); end
        n = (busy === 1'b1) ? 1 : 0;
        gnt_seen = 1'b0;
        while (busy === 1'b1 && n < 2000) begin
            if (gnt !== '0) gnt_seen = 1'b1;
            clr_start = (n == 500);   // ignored while busy
            @(posedge clk); #1;
            if (busy === 1'b1) n++;
        end
        clr_start = 1'b0;
        tests++; if (n != DEPTH) begin fails++; $display("FAIL clear_busy_len: got %0d expected %0d", n, DEPTH); end
        tests++; if (gnt_seen) begin fails++; $display("FAIL clear_gnt_zero: got grant expected none"); end
        #2;
        tests++; if (gnt !== 2'b01) begin fails++; $display("FAIL clear_pending_gnt: got %b expected 01", gnt); end
        req = '0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        int                g, prev_g;
        logic [NUM_CH-1:0] exp_rv;
        idle_inputs();
        req  = 2'b11;
        addr = {15'd20, 15'd10};
        prev_g = -1;
        for (int c = 0; c < 4; c++) begin
            #3;
            g = exp_grant(req);
            tests++; if (gnt !== NUM_CH'(1 << g)) begin fails++; $display("FAIL rr_gnt%0d: got %b expected %b", c, gnt, NUM_CH'(1 << g)); end
            @(posedge clk); #1;
            mptr = (g + 1) % NUM_CH;
            exp_rv = NUM_CH'(1 << g);
            tests++; if (rvalid !== exp_rv) begin fails++; $display("FAIL rr_rvalid%0d: got %b expected %b", c, rvalid, exp_rv); end
            prev_g = g;
        end
        req = '0;
        m_rdata = '0;
        tests++; if (rdata !== '0) begin fails++; $display("FAIL rr_rdata: got %h expected 0", rdata); end
    endtask

    task automatic test_clear_readback();
        logic [NUM_CH-1:0] g, rv;
        logic [DATA_W-1:0] rd;
        int a [3] = '{0, 513, 1023};
        foreach (a[i]) begin
            access(0, 1'b0, a[i], '0, '0, g, rv, rd);
            tests++; if (g !== 2'b01) begin fails++; $display("FAIL clrrd_gnt_%0d: got %b expected 01", a[i], g); end
            tests++; if (rv !== 2'b01) begin fails++; $display("FAIL clrrd_rvalid_%0d: got %b expected 01", a[i], rv); end
            tests++; if (rd !== 32'h0) begin fails++; $display("FAIL clrrd_rdata_%0d: got %h expected 0", a[i], rd); end
        end
    endtask

    task automatic test_write_read();
        logic [NUM_CH-1:0] g, rv;
        logic [DATA_W-1:0] rd;
        access(0, 1'b1, 5, 32'hDEADBEEF, 4'hF, g, rv, rd);
        tests++; if (g !== 2'b01) begin fails++; $display("FAIL wr_gnt: got %b expected 01", g); end
        tests++; if (rv !== 2'b00) begin fails++; $display("FAIL wr_no_rvalid: got %b expected 00", rv); end
        access(0, 1'b0, 5, '0, '0, g, rv, rd);
        tests++; if (g !== 2'b01) begin fails++; $display("FAIL rd_gnt: got %b expected 01", g); end
        tests++; if (rv !== 2'b01) begin fails++; $display("FAIL rd_rvalid: got %b expected 01", rv); end
        tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_after_wr: got %h expected deadbeef", rd); end
        @(posedge clk); #1;
        tests++; if (rvalid !== 2'b00) begin fails++; $display("FAIL rvalid_one_cycle: got %b expected 00", rvalid); end
        tests++; if (rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL rdata_hold: got %h expected deadbeef", rdata); end
    endtask

    task automatic test_byte_enable();
        logic [NUM_CH-1:0] g, rv;
        logic [DATA_W-1:0] rd;
        access(1, 1'b1, 7, 32'h11223344, 4'hF, g, rv, rd);
        access(0, 1'b1, 7, 32'hAABBCCDD, 4'b0101, g, rv, rd);
        access(1, 1'b1, 7, 32'hFFFFFFFF, 4'h0, g, rv, rd);   // no-op write
        tests++; if (g !== 2'b10) begin fails++; $display("FAIL be0_gnt: got %b expected 10", g); end
        access(1, 1'b0, 7, '0, '0, g, rv, rd);
        tests++; if (rv !== 2'b10) begin fails++; $display("FAIL be_rvalid: got %b expected 10", rv); end
        tests++; if (rd !== 32'h11BB33DD) begin fails++; $display("FAIL be_rdata: got %h expected 11bb33dd", rd); end
    endtask

    task automatic test_out_of_range();
        logic [NUM_CH-1:0] g, rv;
        logic [DATA_W-1:0] rd;
        access(0, 1'b1, 0, 32'hA5A50001, 4'hF, g, rv, rd);
        access(0, 1'b1, 1024, 32'h12345678, 4'hF, g, rv, rd);
        tests++; if (g !== 2'b01) begin fails++; $display("FAIL oor_wr_gnt: got %b expected 01", g); end
        access(1, 1'b0, 1024, '0, '0, g, rv, rd);
        tests++; if (rv !== 2'b10) begin fails++; $display("FAIL oor_rvalid: got %b expected 10", rv); end
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL oor_rdata: got %h expected 0", rd); end
        access(0, 1'b0, 32767, '0, '0, g, rv, rd);
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL oor_max_rdata: got %h expected 0", rd); end
        access(0, 1'b0, 0, '0, '0, g, rv, rd);
        tests++; if (rd !== 32'hA5A50001) begin fails++; $display("FAIL oor_word0: got %h expected a5a50001", rd); end
    endtask

    task automatic test_random();
        int                g;
        int                ch_addr [NUM_CH];
        logic [NUM_CH-1:0] exp_rv;
        logic [31:0]       av;
        for (int c = 0; c < 400; c++) begin
            idle_inputs();
            req = NUM_CH'($urandom);
            we  = NUM_CH'($urandom);
            for (int ch = 0; ch < NUM_CH; ch++) begin
                ch_addr[ch] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1020, 1030))
                                                          : int'($urandom_range(0, 31));
                av = ch_addr[ch];
                addr[ch*ADDR_W +: ADDR_W]  = av[ADDR_W-1:0];
                wdata[ch*DATA_W +: DATA_W] = $urandom;
                be[ch*BE_W +: BE_W]        = BE_W'($urandom);
            end
            #3;
            g = exp_grant(req);
            tests++;
            if (gnt !== ((g < 0) ? NUM_CH'(0) : NUM_CH'(1 << g))) begin
                fails++; $display("FAIL rand_gnt%0d: got %b req %b ptr %0d", c, gnt, req, mptr);
            end
            exp_rv = '0;
            if (g >= 0) begin
                mptr = (g + 1) % NUM_CH;
                if (we[g]) begin
                    mdl_write(ch_addr[g], wdata[g*DATA_W +: DATA_W], be[g*BE_W +: BE_W]);
                end else begin
                    exp_rv  = NUM_CH'(1 << g);
                    m_rdata = mdl_read(ch_addr[g]);
                end
            end
            @(posedge clk); #1;
            tests++; if (rvalid !== exp_rv) begin fails++; $display("FAIL rand_rvalid%0d: got %b expected %b", c, rvalid, exp_rv); end
            tests++; if (rdata !== m_rdata) begin fails++; $display("FAIL rand_rdata%0d: got %h expected %h", c, rdata, m_rdata); end
        end
        idle_inputs();
    endtask

    task automatic test_clear_abort();
        bit gnt_seen;
        idle_inputs();
        req       = 2'b01;
        clr_start = 1'b1;
        #3;
        tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL abort_same_cycle_gnt: got %b expected 00", gnt); end
        @(posedge clk); #1;
        clr_start = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL abort_busy: got %b expected 1", busy); end
        gnt_seen = 1'b0;
        for (int c = 1; c < 100; c++) begin
            if (gnt !== '0) gnt_seen = 1'b1;
            @(posedge clk); #1;
        end
        tests++; if (gnt_seen) begin fails++; $display("FAIL abort_gnt_zero: got grant expected none"); end
        #2;
        rst_l = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy_reset: got %b expected 0", busy); end
        tests++; if (gnt !== 2'b00) begin fails++; $display("FAIL abort_gnt_reset: got %b expected 00", gnt); end
        @(posedge clk); @(posedge clk); #1;
        rst_l = 1'b1;
        #2;
        tests++; if (gnt !== 2'b01) begin fails++; $display("FAIL abort_gnt_release: got %b expected 01", gnt); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy_release: got %b expected 0", busy); end
        req = '0;
        @(posedge clk); #1;
    endtask

    initial begin
        idle_inputs();
        mptr    = 0;
        m_rdata = '0;
        test_reset();
        test_clear();
        test_round_robin();
        test_clear_readback();
        test_write_read();
        test_byte_enable();
        test_out_of_range();
        test_random();
        test_clear_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard time limit so the bench can never hang
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/m9k_mp_controller.md
Name: m9k_mp_controller

Overview:
- Parametrised multi-channel successor to the single-port M9K scratchpad controller.
- Arbitrates NUM_CH request channels round-robin onto one inferred M9K-style RAM.
- Read latency is 1 cycle, registered, so the array maps onto block RAM.
- Supports per-byte write enables and a hardware clear sequencer that replaces reset-time array initialisation.

Parameters:
- DATA_W, 32: data word width in bits; must be a multiple of 8.
- ADDR_W, 15: address width per channel.
- DEPTH, 1024: number of words implemented; DEPTH <= 2**ADDR_W.
- NUM_CH, 2: number of requesting channels; NUM_CH >= 1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_l  input  1  asynchronous, active-low reset.
- req  input  NUM_CH  per-channel access request, held until granted.
- we  input  NUM_CH  per-channel 1 = write, 0 = read.
- addr  input  NUM_CH*ADDR_W  per-channel word address; channel i uses slice i.
- wdata  input  NUM_CH*DATA_W  per-channel write data.
- be  input  NUM_CH*(DATA_W/8)  per-channel byte enables; write only.
- gnt  output  NUM_CH  one-hot combinational grant; access accepted when req[i] & gnt[i].
- rvalid  output  NUM_CH  one-cycle pulse: rdata holds the read result for channel i.
- rdata  output  DATA_W  registered read data, shared by all channels.
- clr_start  input  1  single-cycle pulse to start zeroing the whole array.
- busy  output  1  high while the clear sequence runs.

Behaviour:
- Reset (rst_l low, asynchronous):
  - gnt = 0, rvalid = 0, rdata = 0, busy = 0.
  - RR pointer = 0; FSM enters IDLE.
  - Array contents are NOT reset (block-RAM inference). Software must issue a clear before relying on contents.
- FSM states:
  - IDLE -> CLEAR when clr_start = 1.
  - CLEAR -> IDLE after the write to word DEPTH-1.
- IDLE arbitration:
  - gnt is one-hot among asserted req bits: the first asserted channel searching upward from pointer p, wrapping at NUM_CH.
  - gnt = 0 when no req is asserted.
  - On a grant to channel k, p <= (k+1) mod NUM_CH on the next edge. Otherwise p holds.
  - At most one access per cycle.
- Read (granted, we = 0):
  - On the next edge, rdata <= M[addr] and rvalid[k] <= 1 for exactly one cycle.
  - rdata holds its value until the next read completes.
- Write (granted, we = 1):
  - For each byte b with be[b] = 1, M[addr][8b+7:8b] <= wdata byte b.
  - Bytes with be[b] = 0 are unchanged. be = 0 is a legal no-op write that still consumes the grant.
  - No rvalid is produced for writes.
- Read after write, same address, next cycle: returns the newly written data.
- Out-of-range addr (addr >= DEPTH):
  - Write: ignored.
  - Read: returns 0 with a normal rvalid pulse.
  - The grant and pointer update still occur.
- CLEAR:
  - busy = 1 from the edge that samples clr_start.
  - One word per cycle is written to all zeros, address 0..DEPTH-1, taking DEPTH cycles.
  - busy falls on the edge after the final write. Total busy-high time is exactly DEPTH cycles.
  - gnt = 0 throughout; requests stay pending.
  - clr_start while busy is ignored.
- clr_start and req in the same IDLE cycle: clear wins; gnt = 0 that cycle.
- A read granted in the cycle before clr_start still completes its rvalid, which may overlap the first busy cycle.
- Reset mid-CLEAR: sequence aborts, busy = 0, array partially cleared (contents unspecified).
- Width rules:
  - addr slices are compared against DEPTH at full ADDR_W width.
  - The internal clear counter is clog2(DEPTH) + 1 bits so it does not wrap.

Test Plan:
- Reset, then clr_start pulse with DEPTH=1024 -> busy high exactly 1024 cycles; afterwards reads of addresses 0, 513 and 1023 return 0x00000000, each with rvalid one cycle after its grant.
- Ch0 writes 0xDEADBEEF to addr 5 with be=4'hF, then next cycle reads addr 5 -> gnt[0] both cycles, rvalid[0] one cycle after the read, rdata = 0xDEADBEEF.
- Byte enables: write 0x11223344 with be=4'hF, then 0xAABBCCDD with be=4'b0101 to addr 7, then read -> rdata = 0x11BB33DD.
- NUM_CH=2, both channels hold read requests continuously for 4 cycles starting with p=0 -> gnt sequence 01,10,01,10; rvalid alternates in the same order, one cycle later.
- Out-of-range: write 0x12345678 to addr 1024, then read addr 1024 -> rdata = 0, rvalid pulses; word 0 is unchanged.
- req asserted on the same cycle as clr_start, and rst_l dropped at clear cycle 100 -> gnt = 0 throughout; busy = 0 immediately on reset; after release, req is granted in the first IDLE cycle.
